ring_read_scheduler: RTL
========================

// Module: ring_read_scheduler
// PURPOSE
//  Sequences draining of the 8-byte-slot capture RAM onto the UART transmitter. Owns the ring
//  read pointer: detects non-empty, fetches REC_BYTES bytes of the oldest slot from the RAM,
//  hands each byte to uart_tx with a ready/latch handshake, then optionally appends TERM_BYTE.
//  After the last byte it retires the slot with a read_done pulse. Sits between buffer/ringbuffer
//  and uart_tx on the ext_clock domain.
// PARAMETERS
//  PTR_BITS   5      ring slot pointer width; 2**PTR_BITS slots
//  SLOT_BITS  3      byte offset width inside a slot (8 bytes/slot)
//  REC_BYTES  6      bytes sent per record (offsets 0..REC_BYTES-1), 1..2**SLOT_BITS
//  TERM_EN    1      1: append TERM_BYTE after each record
//  TERM_BYTE  8'h0A  record terminator
// PORTS
//  clock          in   1                    single clock, rising edge
//  reset          in   1                    synchronous, active-high
//  enable         in   1                    0: finish current record, then hold in IDLE
//  write_ptr      in   PTR_BITS             ring write pointer, already synchronised to clock
//  read_ptr       out  PTR_BITS             ring read pointer (next slot to drain)
//  read_done      out  1                    1-cycle pulse when a slot is retired
//  read_addr      out  PTR_BITS+SLOT_BITS   RAM byte address {read_ptr, offset}
//  read_clock     out  1                    1-cycle RAM read strobe
//  read_data      in   8                    RAM data, valid the cycle after read_clock
//  uart_data      out  8                    byte to transmit
//  uart_latch     out  1                    1-cycle pulse: uart_data valid
//  uart_ready     in   1                    UART idle; drops within 1 cycle of uart_latch
//  busy           out  1                    high in any state other than IDLE
//  records_sent   out  16                   retired-slot count, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: read_ptr=0, offset=0, read_addr=0, uart_data=0, records_sent=0; read_done,
//   read_clock, uart_latch, busy=0; state=IDLE. Reset mid-record aborts with no latch/done pulse.
//  Empty: read_ptr==write_ptr. Full/overflow is owned by the writer side; not checked here.
//  FSM:
//   IDLE   : enable && !empty -> FETCH, offset=0.
//   FETCH  : read_addr={read_ptr,offset}, read_clock=1 for one cycle -> WAIT.
//   WAIT   : capture read_data into uart_data -> SEND.
//   SEND   : when uart_ready -> uart_latch=1 for one cycle -> HOLD.
//   HOLD   : one cycle, uart_ready ignored (UART deassert window) -> DRAIN.
//   DRAIN  : wait for uart_ready. Then: offset<REC_BYTES-1 -> offset+1, FETCH;
//            else TERM_EN -> TERM; else -> RETIRE.
//   TERM   : uart_data=TERM_BYTE; when uart_ready -> uart_latch=1 -> HOLD2 -> DRAIN2 -> RETIRE.
//   RETIRE : read_done=1, read_ptr+=1 (mod 2**PTR_BITS), records_sent+=1 -> IDLE.
//  Latency from non-empty in IDLE to first uart_latch is 4 cycles with uart_ready high.
//  write_ptr changes during a record do not affect the record in flight. An empty test
//   happens only in IDLE.
//  Deasserting enable mid-record does not truncate it. The record completes, and the FSM
//   then stays in IDLE.
//  read_ptr wraps from 2**PTR_BITS-1 to 0 without a gap. Unused slot bytes are never read.
//  uart_latch and read_clock are never high in the same cycle. Each is at most one cycle wide.
// STRUCTURE
//  Shared package: state encoding (localparam list), SLOT_BYTES=2**SLOT_BITS, TERM default.
//  One natural sub-module: uart_handshake (SEND/HOLD/DRAIN latch-and-wait sequencer), instanced
//   once and reused for data and terminator bytes. Otherwise a flat FSM + counters.
// TESTING
//  1 write_ptr 0->1, RAM slot0 = 11..16, UART model ready 3 cycles after latch
//    -> bytes 11,12,13,14,15,16,0A; one read_done; read_ptr=1; records_sent=1.
//  2 TERM_EN=0, write_ptr 0->3 at once -> 18 bytes slot0,1,2 in order; 3 read_done; read_ptr=3.
//  3 read_ptr=31, write_ptr=0 (wrap) -> read_addr 248..253 read, read_ptr becomes 0, then idle.
//  4 enable drops after 2nd byte -> record finishes (7 latches), no further fetch while
//    write_ptr!=read_ptr; enable=1 resumes next slot.
//  5 reset asserted during DRAIN of byte 3 -> next cycle all outputs at reset values;
//    no read_done; read_ptr=0.
//  6 uart_ready held low 100 cycles in SEND -> no latch, read_clock stays 0, busy=1 throughout.

Source files
------------

// File: rtl/ring_read_scheduler_pkg.sv
// Shared types and defaults for the capture-ring drain scheduler.
// Top-level states cover whole byte transfers; the handshake sub-FSM covers latch-and-wait.
package ring_read_scheduler_pkg;

    localparam int         PTR_BITS_DEF  = 5;
    localparam int         SLOT_BITS_DEF = 3;
    localparam int         SLOT_BYTES    = 2 ** SLOT_BITS_DEF;
    localparam int         REC_BYTES_DEF = 6;
    localparam logic [7:0] TERM_BYTE_DEF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_XFER,
        S_TERM,
        S_RETIRE
    } sched_state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_SEND,
        HS_HOLD,
        HS_DRAIN
    } hs_state_e;

endpackage

// File: rtl/ring_read_scheduler_uart_handshake.sv
// Latch-and-wait sequencer toward uart_tx: wait ready, pulse latch, skip one cycle, wait ready.
// Used for both record bytes and the terminator byte.
module ring_read_scheduler_uart_handshake
    import ring_read_scheduler_pkg::*;
(
    input  logic clock_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic uart_ready_i,
    output logic uart_latch_o,
    output logic done_o
);

    hs_state_e state_q, state_d;
    logic      latch_q, latch_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= HS_IDLE;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch_d = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            HS_IDLE:  if (start_i) state_d = HS_SEND;
            HS_SEND: begin
                if (uart_ready_i) begin
                    latch_d = 1'b1;
                    state_d = HS_HOLD;
                end
            end
            // UART may still show ready for a cycle after the latch; don't trust it here.
            HS_HOLD:  state_d = HS_DRAIN;
            HS_DRAIN: begin
                if (uart_ready_i) begin
                    done_o  = 1'b1;
                    // the terminator is started in the same cycle the last data byte finishes
                    state_d = start_i ? HS_SEND : HS_IDLE;
                end
            end
            default:  state_d = HS_IDLE;
        endcase
    end

    assign uart_latch_o = latch_q;

endmodule

// File: rtl/ring_read_scheduler.sv
// Drains the oldest capture-ring slot byte by byte into uart_tx, then retires the slot.
// Owns the ring read pointer; the empty test is made only while idle.
module ring_read_scheduler
    import ring_read_scheduler_pkg::*;
#(
    parameter int         PTR_BITS  = PTR_BITS_DEF,
    parameter int         SLOT_BITS = SLOT_BITS_DEF,
    parameter int         REC_BYTES = REC_BYTES_DEF,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEF
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [PTR_BITS-1:0]           write_ptr_i,
    output logic [PTR_BITS-1:0]           read_ptr_o,
    output logic                          read_done_o,
    output logic [PTR_BITS+SLOT_BITS-1:0] read_addr_o,
    output logic                          read_clock_o,
    input  logic [7:0]                    read_data_i,
    output logic [7:0]                    uart_data_o,
    output logic                          uart_latch_o,
    input  logic                          uart_ready_i,
    output logic                          busy_o,
    output logic [15:0]                   records_sent_o
);

    localparam logic [SLOT_BITS-1:0] LAST_OFF = SLOT_BITS'(REC_BYTES - 1);

    sched_state_e          state_q, state_d;
    logic [PTR_BITS-1:0]   read_ptr_q, read_ptr_d;
    logic [SLOT_BITS-1:0]  offset_q, offset_d;
    logic [7:0]            uart_data_q, uart_data_d;
    logic [15:0]           records_q, records_d;
    logic                  read_done_q, read_done_d;
    logic                  read_clock_q, read_clock_d;
    logic                  hs_start, hs_done;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            read_ptr_q   <= '0;
            offset_q     <= '0;
            uart_data_q  <= '0;
            records_q    <= '0;
            read_done_q  <= 1'b0;
            read_clock_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_ptr_q   <= read_ptr_d;
            offset_q     <= offset_d;
            uart_data_q  <= uart_data_d;
            records_q    <= records_d;
            read_done_q  <= read_done_d;
            read_clock_q <= read_clock_d;
        end
    end

    // Strobes are registered: read_clock is high during FETCH, read_done in the cycle after RETIRE.
    always_comb begin
        state_d      = state_q;
        read_ptr_d   = read_ptr_q;
        offset_d     = offset_q;
        uart_data_d  = uart_data_q;
        records_d    = records_q;
        read_done_d  = 1'b0;
        read_clock_d = 1'b0;
        hs_start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && (read_ptr_q != write_ptr_i)) begin
                    offset_d     = '0;
                    read_clock_d = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                uart_data_d = read_data_i;
                hs_start    = 1'b1;
                state_d     = S_XFER;
            end
            S_XFER: begin
                if (hs_done) begin
                    if (offset_q != LAST_OFF) begin
                        offset_d     = offset_q + 1'b1;
                        read_clock_d = 1'b1;
                        state_d      = S_FETCH;
                    end else if (TERM_EN) begin
                        uart_data_d = TERM_BYTE;
                        hs_start    = 1'b1;
                        state_d     = S_TERM;
                    end else begin
                        state_d = S_RETIRE;
                    end
                end
            end
            S_TERM: if (hs_done) state_d = S_RETIRE;
            S_RETIRE: begin
                read_done_d = 1'b1;
                read_ptr_d  = read_ptr_q + 1'b1;
                records_d   = records_q + 16'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    ring_read_scheduler_uart_handshake u_hs (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (hs_start),
        .uart_ready_i (uart_ready_i),
        .uart_latch_o (uart_latch_o),
        .done_o       (hs_done)
    );

    assign read_ptr_o     = read_ptr_q;
    assign read_done_o    = read_done_q;
    assign read_addr_o    = {read_ptr_q, offset_q};
    assign read_clock_o   = read_clock_q;
    assign uart_data_o    = uart_data_q;
    assign busy_o         = (state_q != S_IDLE);
    assign records_sent_o = records_q;

endmodule
